// File: rtl/key_matrix_arb_if.sv
// Signal bundle between the key-matrix arbiter, its requesters and the 16x8 key RAM.
interface key_matrix_arb_if;
  logic [3:0] scan_row;
  logic [7:0] scan_data;
  logic       upd_req;
  logic [3:0] upd_row;
  logic [2:0] upd_col;
  logic       upd_val;
  logic       upd_ack;
  logic       clr_req;
  logic       clr_done;
  logic       busy;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  modport slave (
    input  scan_row, upd_req, upd_row, upd_col, upd_val, clr_req, ram_dout,
    output scan_data, upd_ack, clr_done, busy, ram_addr, ram_we, ram_din
  );

  modport master (
    output scan_row, upd_req, upd_row, upd_col, upd_val, clr_req, ram_dout,
    input  scan_data, upd_ack, clr_done, busy, ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/key_matrix_arb.sv
// Arbitrates scan reads, read-modify-write bit updates and full clears of a 16x8 key RAM.
// Define KEYARB_CLR_ON_RESET_EN to run a full clear right after reset release.
module key_matrix_arb (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_ena,
  key_matrix_arb_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StRd, StMod, StWr, StClr} state_e;

  state_e     state_q;
  logic [7:0] scan_data_q;
  logic [3:0] ram_addr_q;
  logic       ram_we_q;
  logic [7:0] ram_din_q;
  logic       upd_ack_q;
  logic       clr_done_q;
  logic       clr_start;
  logic [7:0] mod_word;

`ifdef KEYARB_CLR_ON_RESET_EN
  logic clr_pend_q;

  // Pending clear is armed by reset and consumed on the first enabled edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_pend_q <= 1'b1;
    end else if (clk_ena) begin
      clr_pend_q <= 1'b0;
    end
  end

  assign clr_start = bus.clr_req | clr_pend_q;
  assign bus.busy  = (state_q != StIdle) | clr_pend_q;
`else
  assign clr_start = bus.clr_req;
  assign bus.busy  = (state_q != StIdle);
`endif

  always_comb begin
    mod_word              = bus.ram_dout;
    mod_word[bus.upd_col] = bus.upd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      scan_data_q <= 8'h00;
      ram_addr_q  <= 4'h0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= 8'h00;
      upd_ack_q   <= 1'b0;
      clr_done_q  <= 1'b0;
    end else if (clk_ena) begin
      upd_ack_q  <= 1'b0;
      clr_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          scan_data_q <= bus.ram_dout;
          if (clr_start) begin
            ram_addr_q <= 4'h0;
            ram_din_q  <= 8'h00;
            ram_we_q   <= 1'b1;
            state_q    <= StClr;
          end else if (bus.upd_req) begin
            ram_addr_q <= bus.upd_row;
            ram_we_q   <= 1'b0;
            state_q    <= StRd;
          end else begin
            ram_addr_q <= bus.scan_row;
          end
        end
        // RAM read data for upd_row lands during this state.
        StRd: begin
          state_q <= StMod;
        end
        StMod: begin
          ram_din_q <= mod_word;
          ram_we_q  <= 1'b1;
          state_q   <= StWr;
        end
        StWr: begin
          ram_we_q  <= 1'b0;
          upd_ack_q <= 1'b1;
          state_q   <= StIdle;
        end
        StClr: begin
          if (ram_addr_q == 4'hf) begin
            ram_we_q   <= 1'b0;
            clr_done_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            ram_addr_q <= ram_addr_q + 4'd1;
          end
        end
        default: begin
          ram_we_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign bus.scan_data = scan_data_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.upd_ack   = upd_ack_q;
  assign bus.clr_done  = clr_done_q;

endmodule

// File: tb/tb_key_matrix_arb.sv
// Directed self-checking bench for key_matrix_arb with a read-first synchronous 16x8 RAM model.
module tb_key_matrix_arb;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_ena = 1'b0;

  key_matrix_arb_if bus ();

  key_matrix_arb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_ena (clk_ena),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [7:0] dout_q;
  logic       pl_en;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;

  // RAM samples ram_addr on each enabled edge; read returns the pre-write contents.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (clk_ena) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      dout_q <= mem[bus.ram_addr];
    end
  end

  assign bus.ram_dout = dout_q;

  int checks = 0;
  int errors = 0;
  int gap = 0;

  // One enabled edge, preceded by 'gap' disabled edges; sample 1 ns later.
  task automatic step();
    for (int i = 0; i < gap; i++) begin
      clk_ena = 1'b0;
      @(posedge clk);
      #1;
    end
    clk_ena = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    clk_ena = 1'b0;
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clk_ena = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic do_update(input logic [3:0] row, input logic [2:0] col, input logic val,
                           output int lat);
    bus.upd_row = row;
    bus.upd_col = col;
    bus.upd_val = val;
    bus.upd_req = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (bus.upd_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    bus.upd_req = 1'b0;
  endtask

  task automatic test_reset();
    preload(4'd0, 8'h11);
    do_reset();
    checks++;
    if (bus.scan_data !== 8'h00) begin
      errors++; $display("FAIL reset_scan_data: got %h, expected 00", bus.scan_data);
    end
    checks++;
    if (bus.ram_addr !== 4'h0) begin
      errors++; $display("FAIL reset_ram_addr: got %h, expected 0", bus.ram_addr);
    end
    checks++;
    if (bus.ram_we !== 1'b0 || bus.ram_din !== 8'h00) begin
      errors++; $display("FAIL reset_ram_wr: got we=%b din=%h, expected we=0 din=00",
                         bus.ram_we, bus.ram_din);
    end
    checks++;
    if (bus.upd_ack !== 1'b0 || bus.clr_done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got ack=%b done=%b, expected 0 0",
                         bus.upd_ack, bus.clr_done);
    end
`ifdef KEYARB_CLR_ON_RESET_EN
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b, expected 1", bus.busy);
    end
    begin
      int done_cnt = 0;
      for (int n = 0; n < 20; n++) begin
        step();
        if (bus.clr_done === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 1) begin
        errors++; $display("FAIL reset_clear_done: got %0d pulses, expected 1", done_cnt);
      end
      checks++;
      if (mem[0] !== 8'h00) begin
        errors++; $display("FAIL reset_clear_row0: got %h, expected 00", mem[0]);
      end
    end
`else
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy);
    end
    for (int n = 0; n < 20; n++) step();
    checks++;
    if (mem[0] !== 8'h11) begin
      errors++; $display("FAIL no_clear_without_req: got %h, expected 11", mem[0]);
    end
`endif
  endtask

  task automatic test_scan();
    preload(4'd9, 8'h96);
    preload(4'd12, 8'hC3);
    bus.scan_row = 4'd9;
    repeat (3) step();
    checks++;
    if (bus.scan_data !== 8'h96) begin
      errors++; $display("FAIL scan_row9: got %h, expected 96", bus.scan_data);
    end
    bus.scan_row = 4'd12;
    step();
    checks++;
    if (bus.ram_addr !== 4'd12) begin
      errors++; $display("FAIL scan_addr12: got %h, expected c", bus.ram_addr);
    end
    step();
    checks++;
    if (bus.scan_data !== 8'h96) begin
      errors++; $display("FAIL scan_latency_early: got %h, expected 96", bus.scan_data);
    end
    // Two enabled edges after ram_addr picked up row 12.
    step();
    checks++;
    if (bus.scan_data !== 8'hC3) begin
      errors++; $display("FAIL scan_row12: got %h, expected c3", bus.scan_data);
    end
  endtask

  task automatic test_update_set();
    int lat;
    preload(4'd5, 8'hA0);
    bus.scan_row = 4'd0;
    do_update(4'd5, 3'd2, 1'b1, lat);
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL upd_set_latency: got %0d, expected 4", lat);
    end
    checks++;
    if (mem[5] !== 8'hA4) begin
      errors++; $display("FAIL upd_set_row5: got %h, expected a4", mem[5]);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL upd_set_idle: got busy=%b we=%b, expected 0 0",
                         bus.busy, bus.ram_we);
    end
  endtask

  task automatic test_update_clear_scan();
    int lat;
    preload(4'd3, 8'hFF);
    bus.scan_row = 4'd3;
    do_update(4'd3, 3'd7, 1'b0, lat);
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL upd_clr_latency: got %0d, expected 4", lat);
    end
    checks++;
    if (mem[3] !== 8'h7F) begin
      errors++; $display("FAIL upd_clr_row3: got %h, expected 7f", mem[3]);
    end
    repeat (2) step();
    checks++;
    if (bus.scan_data !== 8'h7F) begin
      errors++; $display("FAIL upd_clr_scan: got %h, expected 7f", bus.scan_data);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    preload(4'd2, 8'h00);
    do_update(4'd2, 3'd3, 1'b1, lat1);
    do_update(4'd2, 3'd4, 1'b1, lat2);
    checks++;
    if (lat1 != 4 || lat2 != 4) begin
      errors++; $display("FAIL b2b_latency: got %0d/%0d, expected 4/4", lat1, lat2);
    end
    checks++;
    if (mem[2] !== 8'h18) begin
      errors++; $display("FAIL b2b_row2: got %h, expected 18", mem[2]);
    end
  endtask

  task automatic test_clr_priority();
    int nz = 0, done_at = -1, ack_at = -1, overlap = 0, done_cnt = 0;
    for (int r = 0; r < 16; r++) preload(r[3:0], 8'hFF);
    bus.upd_row = 4'd6;
    bus.upd_col = 3'd1;
    bus.upd_val = 1'b1;
    bus.clr_req = 1'b1;
    bus.upd_req = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (done_at < 0 && bus.ram_we === 1'b1 && bus.ram_din === 8'h00 &&
          bus.ram_addr === nz[3:0]) nz++;
      if (bus.upd_ack === 1'b1 && bus.clr_done === 1'b1) overlap++;
      if (bus.clr_done === 1'b1) begin
        done_cnt++;
        done_at = n;
        bus.clr_req = 1'b0;
      end
      if (bus.upd_ack === 1'b1) begin
        ack_at = n;
        bus.upd_req = 1'b0;
        break;
      end
    end
    bus.clr_req = 1'b0;
    bus.upd_req = 1'b0;
    checks++;
    if (nz != 16) begin
      errors++; $display("FAIL prio_zero_writes: got %0d, expected 16", nz);
    end
    checks++;
    if (done_at != 17 || done_cnt != 1) begin
      errors++; $display("FAIL prio_clr_done: got edge %0d x%0d, expected edge 17 x1",
                         done_at, done_cnt);
    end
    checks++;
    if (ack_at != 21) begin
      errors++; $display("FAIL prio_upd_ack: got edge %0d, expected 21", ack_at);
    end
    checks++;
    if (overlap != 0) begin
      errors++; $display("FAIL prio_overlap: got %0d, expected 0", overlap);
    end
    checks++;
    if (mem[6] !== 8'h02 || mem[0] !== 8'h00 || mem[15] !== 8'h00 || mem[7] !== 8'h00) begin
      errors++; $display("FAIL prio_ram: got r6=%h r0=%h r15=%h r7=%h, expected 02 00 00 00",
                         mem[6], mem[0], mem[15], mem[7]);
    end
  endtask

  task automatic test_clk_ena();
    int lat;
    gap = 2;
    preload(4'd10, 8'h5A);
    do_update(4'd10, 3'd0, 1'b1, lat);
    checks++;
    if (lat != 4) begin
      errors++; $display("FAIL ena_latency: got %0d, expected 4", lat);
    end
    checks++;
    if (mem[10] !== 8'h5B) begin
      errors++; $display("FAIL ena_row10: got %h, expected 5b", mem[10]);
    end
    clk_ena = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.upd_ack !== 1'b1) begin
      errors++; $display("FAIL ena_ack_hold: got %b, expected 1", bus.upd_ack);
    end
    gap = 0;
    step();
  endtask

  task automatic test_clr_during_update();
    int ack_at = -1, done_at = -1;
    logic [7:0] row_at_ack = 8'hxx;
    preload(4'd4, 8'h81);
    bus.upd_row = 4'd4;
    bus.upd_col = 3'd0;
    bus.upd_val = 1'b0;
    bus.upd_req = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 2) bus.clr_req = 1'b1;
      if (bus.upd_ack === 1'b1) begin
        ack_at = n;
        row_at_ack = mem[4];
        bus.upd_req = 1'b0;
      end
      if (bus.clr_done === 1'b1) begin
        done_at = n;
        bus.clr_req = 1'b0;
        break;
      end
    end
    bus.clr_req = 1'b0;
    bus.upd_req = 1'b0;
    checks++;
    if (ack_at != 4 || row_at_ack !== 8'h80) begin
      errors++; $display("FAIL mid_clr_update: got edge %0d row %h, expected edge 4 row 80",
                         ack_at, row_at_ack);
    end
    checks++;
    if (done_at != 21) begin
      errors++; $display("FAIL mid_clr_done: got edge %0d, expected 21", done_at);
    end
    checks++;
    if (mem[4] !== 8'h00) begin
      errors++; $display("FAIL mid_clr_row4: got %h, expected 00", mem[4]);
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    logic [7:0] exp7;
`ifdef KEYARB_CLR_ON_RESET_EN
    exp7 = 8'h00;
`else
    exp7 = 8'h3C;
`endif
    preload(4'd7, 8'h3C);
    bus.upd_row = 4'd7;
    bus.upd_col = 3'd1;
    bus.upd_val = 1'b1;
    // Reset while in MOD.
    bus.upd_req = 1'b1;
    repeat (2) step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ram_we !== 1'b0 || bus.upd_ack !== 1'b0) begin
      errors++; $display("FAIL rst_mod_outputs: got we=%b ack=%b, expected 0 0",
                         bus.ram_we, bus.upd_ack);
    end
    bus.upd_req = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.upd_ack === 1'b1) acks++;
    end
    checks++;
    if (mem[7] !== exp7 || acks != 0) begin
      errors++; $display("FAIL rst_mod_ram: got row7=%h acks=%0d, expected %h 0",
                         mem[7], acks, exp7);
    end
    // Reset while the write is armed in WR.
    preload(4'd7, 8'h3C);
    bus.upd_req = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.ram_we !== 1'b1) begin
      errors++; $display("FAIL rst_wr_armed: got we=%b, expected 1", bus.ram_we);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL rst_wr_async: got we=%b, expected 0", bus.ram_we);
    end
    bus.upd_req = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.upd_ack === 1'b1) acks++;
    end
    checks++;
    if (mem[7] !== exp7 || acks != 0) begin
      errors++; $display("FAIL rst_wr_ram: got row7=%h acks=%0d, expected %h 0",
                         mem[7], acks, exp7);
    end
  endtask

  initial begin
    pl_en        = 1'b0;
    pl_addr      = 4'h0;
    pl_data      = 8'h00;
    bus.scan_row = 4'h0;
    bus.upd_req  = 1'b0;
    bus.upd_row  = 4'h0;
    bus.upd_col  = 3'h0;
    bus.upd_val  = 1'b0;
    bus.clr_req  = 1'b0;
    test_reset();
    test_scan();
    test_update_set();
    test_update_clear_scan();
    test_back_to_back();
    test_clr_priority();
    test_clk_ena();
    test_clr_during_update();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
